// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel used by fetch_unit.
// The fetch stage drives the master side: req/addr out, ready/rvalid/rdata in.
// The memory (or a testbench model) drives the slave side.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               req;     // fetch request, held until accepted
    logic [ADDR_W-1:0]  addr;    // fetch address, stable while req && !ready
    logic               ready;   // memory accepts the request this cycle
    logic               rvalid;  // response valid, one cycle per accepted request
    logic [INSTR_W-1:0] rdata;   // fetched instruction

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request
// handshake to instruction memory, and presents the IF/ID register to decode.
// Redirects (EX branch over decode jump) flush IF/ID and discard any response
// still in flight. Define FETCH_PERF_CNT_EN to add the perf_fetched and
// perf_bubbles counters as extra outputs.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    input  logic               id_stall,
    input  logic [1:0]         jmp_sel,
    input  logic [ADDR_W-1:0]  jmp_imm_target,
    input  logic [ADDR_W-1:0]  jmp_reg_target,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,  // first cycle after reset release
        S_REQ,   // request presented, waiting for acceptance
        S_WAIT,  // request accepted, waiting for the response
        S_HOLD   // response parked in the buffer while decode stalls
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic               kill, kill_nx;          // in-flight response must be dropped
    logic [ADDR_W-1:0]  req_addr, req_addr_nx;  // address of the outstanding request
    logic [INSTR_W-1:0] buf_instr, buf_instr_nx;
    logic [ADDR_W-1:0]  buf_pc, buf_pc_nx;
    logic               if_valid_nx;
    logic [INSTR_W-1:0] if_instr_nx;
    logic [ADDR_W-1:0]  if_pc_nx;

    logic               accept;
    logic               jmp_valid;
    logic               redirect;
    logic [ADDR_W-1:0]  target;

    // Redirect request and target: EX branch wins over decode's jump, and a
    // jump is only honoured while IF/ID actually holds the jumping instruction.
    always_comb begin
        jmp_valid = if_valid && (jmp_sel == 2'b01 || jmp_sel == 2'b10);
        redirect  = branch_taken || jmp_valid;
        if (branch_taken)          target = branch_target;
        else if (jmp_sel == 2'b01) target = jmp_imm_target;
        else                       target = jmp_reg_target;
    end

    assign accept    = (state == S_REQ) && imem.ready;
    assign imem.req  = (state == S_REQ);
    assign imem.addr = pc;

    // State register and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            req_addr  <= '0;
            // NOTE: the one-entry buffer is plain flops, so it is reset with everything else.
            buf_instr <= '0;
            buf_pc    <= '0;
            if_valid  <= 1'b0;
            if_instr  <= '0;
            if_pc     <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            kill      <= kill_nx;
            req_addr  <= req_addr_nx;
            buf_instr <= buf_instr_nx;
            buf_pc    <= buf_pc_nx;
            if_valid  <= if_valid_nx;
            if_instr  <= if_instr_nx;
            if_pc     <= if_pc_nx;
        end
    end

    // Next-state, PC and IF/ID update; a redirect overrides the normal flow last.
    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        state_nx     = state;
        pc_nx        = pc;
        kill_nx      = kill;
        req_addr_nx  = req_addr;
        buf_instr_nx = buf_instr;
        buf_pc_nx    = buf_pc;
        if_instr_nx  = if_instr;
        if_pc_nx     = if_pc;
        // Decode consumes IF/ID every unstalled cycle; without a new load it becomes a bubble.
        if_valid_nx  = id_stall ? if_valid : 1'b0;

        unique case (state)
            S_IDLE: state_nx = S_REQ;
            S_REQ: begin
                if (accept) begin
                    state_nx    = S_WAIT;
                    req_addr_nx = pc;
                    pc_nx       = pc + ADDR_W'(PC_STEP);
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_nx = S_REQ;
                    if (kill) begin
                        kill_nx = 1'b0;
                    end else if (!id_stall) begin
                        if_valid_nx = 1'b1;
                        if_instr_nx = imem.rdata;
                        if_pc_nx    = req_addr;
                    end else begin
                        buf_instr_nx = imem.rdata;
                        buf_pc_nx    = req_addr;
                        state_nx     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    if_valid_nx = 1'b1;
                    if_instr_nx = buf_instr;
                    if_pc_nx    = buf_pc;
                    state_nx    = S_REQ;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (redirect) begin
            pc_nx        = target;
            if_valid_nx  = 1'b0;
            buf_instr_nx = '0;
            buf_pc_nx    = '0;
            unique case (state)
                S_REQ: begin
                    // An old request accepted on the redirect edge is still in flight.
                    state_nx = accept ? S_WAIT : S_REQ;
                    kill_nx  = accept;
                end
                S_WAIT: begin
                    // A response arriving on the redirect edge is simply dropped.
                    state_nx = imem.rvalid ? S_REQ : S_WAIT;
                    kill_nx  = !imem.rvalid;
                end
                S_HOLD:  state_nx = S_REQ;
                default: state_nx = S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic loaded;
    // With no stall, IF/ID is only valid next cycle if something was loaded into it.
    assign loaded = !id_stall && if_valid_nx;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (loaded)               perf_fetched <= perf_fetched + 32'd1;
            if (!if_valid && !id_stall) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder/control unit.
- Owns the PC, issues requests to instruction memory over a request/ready/rvalid handshake, and presents the IF/ID register.
- The IF/ID register (if_instr, if_pc, if_valid) feeds opcode [31:27] and ALU-op [26:24] to decode.
- Consumes decode's jump select and EX's branch resolution to redirect the PC; handles stalls and flushes.

Parameters:
ADDR_W, 32, PC and instruction-memory address width
INSTR_W, 32, instruction width
PC_STEP, 4, sequential PC increment (byte addressing)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until accepted
imem_addr  out  ADDR_W  fetch address, stable while imem_req && !imem_ready
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response data valid (one cycle per accepted request)
imem_rdata  in  INSTR_W  fetched instruction
id_stall  in  1  hazard unit: hold IF/ID contents
jmp_sel  in  2  from decode: 00 sequential, 01 immediate target, 10 register target (JR), 11 reserved = 00
jmp_imm_target  in  ADDR_W  target for jmp_sel=01
jmp_reg_target  in  ADDR_W  target for jmp_sel=10
branch_taken  in  1  from EX: resolved taken branch
branch_target  in  ADDR_W  target for branch_taken
if_valid  out  1  IF/ID holds a live instruction
if_instr  out  INSTR_W  IF/ID instruction
if_pc  out  ADDR_W  address of if_instr

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, buffer empty, kill=0.
- At most one request outstanding. Accepted on an edge where imem_req && imem_ready. The response's imem_rvalid arrives at least one cycle later.
- States:
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req=1, imem_addr=pc. On acceptance -> WAIT, pc <= pc+PC_STEP (modulo 2^ADDR_W).
  - WAIT: on imem_rvalid with kill=0:
    - If id_stall=0: load if_instr=imem_rdata, if_pc=addr of request, if_valid=1 -> REQ.
    - If id_stall=1: store rdata/addr in one-entry buffer -> HOLD.
    - On imem_rvalid with kill=1: discard, clear kill -> REQ.
  - HOLD: imem_req=0. When id_stall=0: buffer -> IF/ID, if_valid=1, buffer cleared -> REQ.
- Request-to-decode latency: a response on cycle N, with no stall, is visible on if_* at N+1.
- Stall: while id_stall=1, if_* hold; no new request leaves REQ unaccepted-only (a request already held in REQ may still be accepted).
- Redirect: branch_taken has priority over jmp_sel. Target = branch_target, else jmp_imm_target (01), else jmp_reg_target (10). On the redirect edge:
  - pc <= target.
  - if_valid <= 0 (flush, overrides id_stall).
  - Buffer cleared.
  - State: WAIT sets kill=1 and stays in WAIT; HOLD/REQ -> REQ. In REQ, if the same edge accepts the old request, treat it as WAIT+kill.
- Redirect in REQ before acceptance may change imem_addr (request not yet accepted).
- Simultaneous rvalid (kill=0) and redirect: response dropped, no kill set, -> REQ with new pc.
- jmp_sel is sampled only when if_valid=1; ignored otherwise.
- Reset mid-transaction: all state cleared. A later stray rvalid while in IDLE/REQ is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32, increments per instruction loaded into IF/ID) and perf_bubbles (32, increments each cycle if_valid=0 and id_stall=0). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready=1, rvalid one cycle after each accept, rdata=addr^0xA5A5A5A5 -> imem_addr sequence 0,4,8,12; if_pc follows with if_valid=1 and matching if_instr.
- id_stall=1 for 3 cycles while a response arrives at addr 8 -> if_* hold addr 4; buffer delivers addr 8 the cycle after the stall drops; no request is issued during HOLD.
- jmp_sel=01, jmp_imm_target=0x100 while a fetch of 0x10 is outstanding -> if_valid=0 next cycle; the 0x10 response is discarded; next imem_addr=0x100.
- branch_taken=1 (target 0x40) and jmp_sel=10 (target 0x80) in the same cycle -> next fetch address 0x40.
- rst_n low during WAIT, then stray rvalid after release -> if_valid remains 0; first request at RESET_PC.
- imem_ready low for 5 cycles -> imem_req and imem_addr stay stable; a single accept follows.
